// File: rtl/mult_hilo_ctrl_if.sv
// Bundle between the MULT sequencer, the datapath/control unit and the Booth multiplier.
//   slave  : the sequencer (mult_hilo_ctrl)
//   master : the surrounding datapath, control unit and multiplier
// Request side : start, rs_val, rt_val, mthi, mtlo, wr_data
// Multiplier   : mult_a, mult_b, mult_rst_local out; mult_hi, mult_lo back
// Status/regs  : busy, done, hi, lo
interface mult_hilo_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] mult_hi;
  logic [WIDTH-1:0] mult_lo;
  logic [WIDTH-1:0] mult_a;
  logic [WIDTH-1:0] mult_b;
  logic             mult_rst_local;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport slave (
    input  start, rs_val, rt_val, mthi, mtlo, wr_data, mult_hi, mult_lo,
    output mult_a, mult_b, mult_rst_local, busy, done, hi, lo
  );

  modport master (
    output start, rs_val, rt_val, mthi, mtlo, wr_data, mult_hi, mult_lo,
    input  mult_a, mult_b, mult_rst_local, busy, done, hi, lo
  );
endinterface

// File: rtl/mult_hilo_ctrl.sv
// Sequencer for a multi-cycle Booth multiplier plus the architectural HI/LO registers.
// Accepts a MULT in IDLE, latches the operands, strobes the multiplier's local reset for one
// cycle to load them, counts ITER iteration edges, then captures the product into HI/LO and
// pulses done. mthi/mtlo writes are serviced only in IDLE.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : mult_hilo_ctrl_if slave modport (requests, multiplier link, busy/done, HI/LO)
module mult_hilo_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  mult_hilo_ctrl_if.slave  bus
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StLoad    = 2'd1;
  localparam logic [1:0] StRun     = 2'd2;
  localparam logic [1:0] StCapture = 2'd3;

  // Counter value seen on the ITER-th RUN edge.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(ITER - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mult_a_q, mult_a_d;
  logic [WIDTH-1:0] mult_b_q, mult_b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mult_a_d = mult_a_q;
    mult_b_d = mult_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        // start wins over a simultaneous mthi/mtlo, which are then dropped.
        if (bus.start) begin
          mult_a_d = bus.rs_val;
          mult_b_d = bus.rt_val;
          state_d  = StLoad;
        end else begin
          if (bus.mthi) hi_d = bus.wr_data;
          if (bus.mtlo) lo_d = bus.wr_data;
        end
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = StCapture;
      end
      StCapture: begin
        hi_d    = bus.mult_hi;
        lo_d    = bus.mult_lo;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mult_a_q <= '0;
      mult_b_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mult_a_q <= mult_a_d;
      mult_b_q <= mult_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  // Status is decoded from the state register so an async reset clears it immediately.
  assign bus.mult_a         = mult_a_q;
  assign bus.mult_b         = mult_b_q;
  assign bus.mult_rst_local = (state_q == StLoad);
  assign bus.busy           = (state_q != StIdle);
  assign bus.done           = done_q;
  assign bus.hi             = hi_q;
  assign bus.lo             = lo_q;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Bench for mult_hilo_ctrl: randomized MULTs and HI/LO writes, a signed-product scoreboard and
// a behavioural multiplier that presents its result only after ITER iteration edges.
module tb_mult_hilo_ctrl;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned ITER  = 32;
  localparam int          LAT   = ITER + 2;  // accept edge to done edge

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mult_hilo_ctrl_if #(.WIDTH(WIDTH)) bus ();

  mult_hilo_ctrl #(.WIDTH(WIDTH), .ITER(ITER), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          acc;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] arch_hi = '0;
  logic [31:0] arch_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] x, y;
    x = {{32{a[31]}}, a};
    y = {{32{b[31]}}, b};
    return x * y;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Behavioural multiplier: loads on a strobed edge, result valid only after ITER more edges.
  logic [63:0] m_prod;
  int          m_cnt;
  bit          m_loaded;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_loaded <= 1'b0;
      m_cnt    <= 0;
      m_prod   <= '0;
    end else if (bus.mult_rst_local) begin
      m_prod   <= smul(bus.mult_a, bus.mult_b);
      m_cnt    <= 0;
      m_loaded <= 1'b1;
    end else if (m_loaded) begin
      m_cnt <= m_cnt + 1;
    end
  end
  always @(negedge clk) begin
    if (m_loaded && m_cnt == ITER) begin
      bus.mult_hi = m_prod[63:32];
      bus.mult_lo = m_prod[31:0];
    end else begin
      bus.mult_hi = $urandom;
      bus.mult_lo = $urandom;
    end
  end

  // Monitor: status and HI/LO every cycle against the scoreboard head and architectural model.
  always @(negedge clk) begin
    bit eb, er, ed;
    if (sb.size() > 0 && cyc > sb[0].due) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done by cycle %0d, required at cycle %0d", cyc, sb[0].due);
      void'(sb.pop_front());
    end
    eb = (sb.size() > 0) && (cyc < sb[0].due);
    er = (sb.size() > 0) && (cyc == sb[0].acc);
    ed = (sb.size() > 0) && (cyc == sb[0].due);
    chk("busy", 64'(bus.busy), 64'(eb));
    chk("mult_rst_local", 64'(bus.mult_rst_local), 64'(er));
    chk("done", 64'(bus.done), 64'(ed));
    if (ed) begin
      arch_hi = sb[0].hi;
      arch_lo = sb[0].lo;
      void'(sb.pop_front());
    end
    chk("hi", 64'(bus.hi), 64'(arch_hi));
    chk("lo", 64'(bus.lo), 64'(arch_lo));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
  endtask

  task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input bit with_mthi);
    logic [63:0] p;
    exp_t        e;
    bus.start   = 1'b1;
    bus.rs_val  = a;
    bus.rt_val  = b;
    bus.mthi    = with_mthi;
    bus.wr_data = $urandom;
    tick();
    idle_inputs();
    p     = smul(a, b);
    e.hi  = p[63:32];
    e.lo  = p[31:0];
    e.acc = cyc;
    e.due = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    repeat (LAT) tick();
  endtask

  task automatic write_hilo(input bit h, input bit l, input logic [31:0] data);
    bus.mthi    = h;
    bus.mtlo    = l;
    bus.wr_data = data;
    tick();
    idle_inputs();
    if (h) arch_hi = data;
    if (l) arch_lo = data;
  endtask

  initial begin
    idle_inputs();
    bus.rs_val  = '0;
    bus.rt_val  = '0;
    bus.wr_data = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_mult_rst_local", 64'(bus.mult_rst_local), 64'd0);
    chk("reset_mult_a", 64'(bus.mult_a), 64'd0);
    chk("reset_mult_b", 64'(bus.mult_b), 64'd0);
    chk("reset_hi", 64'(bus.hi), 64'd0);
    chk("reset_lo", 64'(bus.lo), 64'd0);
    reset = 1'b0;
    tick();

    // 7 * 6
    do_mult(32'd7, 32'd6, 1'b0);
    wait_done();
    chk("mul7x6_hi", 64'(bus.hi), 64'h0);
    chk("mul7x6_lo", 64'(bus.lo), 64'h2A);
    tick();

    // Signed products
    do_mult(32'hFFFF_FFFD, 32'd5, 1'b0);
    wait_done();
    chk("mulm3x5_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    chk("mulm3x5_lo", 64'(bus.lo), 64'hFFFF_FFF1);
    tick();
    do_mult(32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_done();
    chk("mulmin_hi", 64'(bus.hi), 64'h4000_0000);
    chk("mulmin_lo", 64'(bus.lo), 64'h0);
    tick();

    // mthi/mtlo on the same edge, then mtlo alone
    write_hilo(1'b1, 1'b1, 32'h1234);
    chk("mthi_both_hi", 64'(bus.hi), 64'h1234);
    chk("mtlo_both_lo", 64'(bus.lo), 64'h1234);
    write_hilo(1'b0, 1'b1, 32'h5678);
    chk("mtlo_only_hi", 64'(bus.hi), 64'h1234);
    chk("mtlo_only_lo", 64'(bus.lo), 64'h5678);

    // start together with mthi: write dropped, MULT proceeds
    do_mult(32'd100, 32'd3, 1'b1);
    chk("start_mthi_hi_kept", 64'(bus.hi), 64'h1234);
    wait_done();
    chk("start_mthi_lo", 64'(bus.lo), 64'd300);
    tick();

    // Requests while busy are ignored
    do_mult($urandom, $urandom, 1'b0);
    repeat (9) tick();
    bus.start   = 1'b1;
    bus.mthi    = 1'b1;
    bus.mtlo    = 1'b1;
    bus.rs_val  = $urandom;
    bus.rt_val  = $urandom;
    bus.wr_data = $urandom;
    tick();
    idle_inputs();
    repeat (LAT - 10) tick();
    tick();

    // Asynchronous reset mid-operation
    do_mult($urandom, $urandom, 1'b0);
    repeat (19) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_mult_rst_local", 64'(bus.mult_rst_local), 64'd0);
    chk("midrst_hi", 64'(bus.hi), 64'd0);
    chk("midrst_lo", 64'(bus.lo), 64'd0);
    sb.delete();
    arch_hi = '0;
    arch_lo = '0;
    tick();
    reset = 1'b0;
    tick();
    do_mult(32'd9, 32'd9, 1'b0);
    wait_done();
    chk("after_rst_lo", 64'(bus.lo), 64'd81);
    tick();

    // Back-to-back: second start in the done cycle
    do_mult($urandom, $urandom, 1'b0);
    wait_done();
    do_mult(32'd2, 32'd3, 1'b0);
    wait_done();
    chk("b2b_hi", 64'(bus.hi), 64'd0);
    chk("b2b_lo", 64'(bus.lo), 64'd6);

    // Random mix
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) write_hilo(1'($urandom), 1'($urandom), $urandom);
      do_mult($urandom, $urandom, 1'($urandom));
      wait_done();
      if ($urandom_range(0, 1) == 1) tick();
    end

    repeat (3) tick();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
